// File: rtl/targ_rx_buffer.sv
// -----------------------------------------------------------------------------
// targ_rx_buffer
//   Receive-side byte buffer behind the target UART receiver. The most recent
//   good byte waits in a one-entry staging register until its end-of-packet
//   tag is known, meaning until the next byte or the idle strobe arrives. It is
//   then committed as a 9-bit entry {tag, byte} into a first-word-fall-through
//   FIFO that the register interface drains.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   rx_data           received byte, qualified by rx_data_ready
//   rx_data_ready     strobe: good byte
//   rx_data_error     strobe: framing error (counted, byte discarded)
//   rx_endofpacket    strobe: line idle after a burst (tags staged byte)
//   rx_idle           receiver idle level (status only)
//   clear             synchronous flush of all state
//   rd_en             pop head entry (ignored when empty)
//   rd_data           head entry {eop_tag, byte}, valid when rd_valid
//   rd_valid          FIFO non-empty
//   fifo_count        entries stored
//   pkt_count         stored entries carrying tag=1
//   pending           staging register holds an uncommitted byte
//   overflow          sticky: a commit was dropped on a full FIFO
//   err_count         saturating framing-error count
// -----------------------------------------------------------------------------
module targ_rx_buffer #(
  parameter int DEPTH_LOG2   = 5,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_ready,
  input  logic                    rx_data_error,
  input  logic                    rx_endofpacket,
  input  logic                    rx_idle,
  input  logic                    clear,
  input  logic                    rd_en,
  output logic [8:0]              rd_data,
  output logic                    rd_valid,
  output logic [DEPTH_LOG2:0]     fifo_count,
  output logic [DEPTH_LOG2:0]     pkt_count,
  output logic                    pending,
  output logic                    overflow,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Storage array: no reset, contents are only meaningful between pointers.
  logic [8:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     fifo_count_q, fifo_count_d;
  logic [DEPTH_LOG2:0]     pkt_count_q, pkt_count_d;
  logic [7:0]              stg_data_q, stg_data_d;
  logic                    pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;

  logic       pop;
  logic       commit;
  logic       commit_tag;
  logic       full;
  logic       push;
  logic       wr_en;
  logic [8:0] wr_entry;
  logic       head_tag;

  // rx_idle is status-only; nothing in the datapath depends on it.
  logic unused_rx_idle;
  assign unused_rx_idle = rx_idle;

  assign head_tag = mem_q[rd_ptr_q][8];

  always_comb begin
    pop        = rd_en && (fifo_count_q != '0);
    // A staged byte is committed whenever its successor or the idle strobe
    // shows up; the tag is set only when the packet actually ended.
    commit     = pending_q && (rx_data_ready || rx_endofpacket);
    commit_tag = rx_data_ready ? rx_endofpacket : 1'b1;
    full       = (fifo_count_q == FULL_COUNT);
    // A full FIFO still accepts the commit when the head leaves this cycle.
    push       = commit && (!full || pop);
    wr_en      = push && !clear;
    wr_entry   = {commit_tag, stg_data_q};

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    pkt_count_d  = pkt_count_q;
    stg_data_d   = stg_data_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    err_count_d  = err_count_q;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
      pkt_count_d  = '0;
      stg_data_d   = '0;
      pending_d    = 1'b0;
      overflow_d   = 1'b0;
      err_count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

      if (push && !pop)      fifo_count_d = fifo_count_q + (DEPTH_LOG2+1)'(1);
      else if (!push && pop) fifo_count_d = fifo_count_q - (DEPTH_LOG2+1)'(1);

      if ((push && commit_tag) && !(pop && head_tag))
        pkt_count_d = pkt_count_q + (DEPTH_LOG2+1)'(1);
      else if (!(push && commit_tag) && (pop && head_tag))
        pkt_count_d = pkt_count_q - (DEPTH_LOG2+1)'(1);

      if (commit && !push) overflow_d = 1'b1;

      // Staging updates regardless of whether the commit was accepted.
      if (rx_data_ready) begin
        stg_data_d = rx_data;
        pending_d  = 1'b1;
      end else if (rx_endofpacket) begin
        pending_d  = 1'b0;
      end

      if (rx_data_error && (err_count_q != '1))
        err_count_d = err_count_q + ERRCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      pkt_count_q  <= '0;
      stg_data_q   <= '0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      pkt_count_q  <= pkt_count_d;
      stg_data_q   <= stg_data_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      err_count_q  <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is read combinationally so a committed byte appears one cycle later.
  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (fifo_count_q != '0);
  assign fifo_count = fifo_count_q;
  assign pkt_count  = pkt_count_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_targ_rx_buffer.sv
module tb_targ_rx_buffer;
  localparam int DL    = 5;
  localparam int EW    = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_data_ready = 1'b0;
  logic          rx_data_error = 1'b0;
  logic          rx_endofpacket = 1'b0;
  logic          rx_idle = 1'b0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [8:0]    rd_data;
  logic          rd_valid;
  logic [DL:0]   fifo_count;
  logic [DL:0]   pkt_count;
  logic          pending;
  logic          overflow;
  logic [EW-1:0] err_count;

  targ_rx_buffer #(.DEPTH_LOG2(DL), .ERRCNT_WIDTH(EW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data),
    .rx_data_ready(rx_data_ready), .rx_data_error(rx_data_error),
    .rx_endofpacket(rx_endofpacket), .rx_idle(rx_idle), .clear(clear),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .pkt_count(pkt_count), .pending(pending),
    .overflow(overflow), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose_pops = 1'b0;

  // Reference model: a queue of {tag, byte} entries plus staging state.
  logic [8:0] mq[$];
  logic [7:0] m_stg;
  bit         m_pend;
  bit         m_ovf;
  int         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stg  = '0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_err  = 0;
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i][8]) n++;
    return n;
  endfunction

  task automatic model_step(input bit rdy, input logic [7:0] d, input bit er,
                            input bit eop, input bit rd, input bit clr);
    bit         was_full;
    bit         do_commit;
    logic [8:0] ent;
    logic [8:0] popped;
    if (clr) begin
      model_reset();
      return;
    end
    was_full  = (mq.size() == DEPTH);
    do_commit = m_pend && (rdy || eop);
    ent       = {(rdy ? eop : 1'b1), m_stg};
    if (rd && mq.size() > 0) begin
      popped = mq.pop_front();
      if (verbose_pops) $display("pop %03h", popped);
      was_full = 1'b0;
    end
    if (do_commit) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(ent);
    end
    if (rdy) begin
      m_stg  = d;
      m_pend = 1'b1;
    end else if (eop) begin
      m_pend = 1'b0;
    end
    if (er && m_err < (1 << EW) - 1) m_err++;
  endtask

  task automatic model_compare();
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("pkt_count", 32'(pkt_count), 32'(model_pkts()));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  // One clock with the given inputs; model advanced and compared after edge.
  task automatic cyc(input bit rdy, input logic [7:0] d, input bit er, input bit eop,
                     input bit rd, input bit clr, input bit idle);
    rx_data_ready  = rdy;
    rx_data        = d;
    rx_data_error  = er;
    rx_endofpacket = eop;
    rd_en          = rd;
    clear          = clr;
    rx_idle        = idle;
    model_step(rdy, d, er, eop, rd, clr);
    @(posedge clk);
    #1;
    model_compare();
  endtask

  typedef struct {
    bit         rdy;
    logic [7:0] d;
    bit         er, eop, rd, clr, idle;
    bit         ev;
    logic [8:0] ed;
    int         ecnt, epkt;
    bit         epend;
    int         eerr;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b1, 0};
    tbl[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h041, 1, 0, 1'b1, 0};
    tbl[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h041, 2, 0, 1'b1, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h041, 3, 1, 1'b0, 0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h042, 2, 1, 1'b0, 0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h143, 1, 1, 1'b0, 0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b0, 0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b0, 0};
    tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b1, 0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 0, 0, 1'b1, 0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h15A, 1, 1, 1'b0, 0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h15A, 1, 1, 1'b0, 0};
    tbl[12] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h15A, 1, 1, 1'b1, 0};
    tbl[13] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h15A, 2, 2, 1'b1, 0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h10F, 1, 1, 1'b1, 0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h110, 1, 1, 1'b0, 0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b0, 0};
    tbl[17] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 0, 0, 1'b1, 1};
    tbl[18] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 0, 0, 1'b0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rdy, tbl[i].d, tbl[i].er, tbl[i].eop, tbl[i].rd, tbl[i].clr, tbl[i].idle);
      $display("vec %0d: valid=%0b rd_data=%03h count=%0d pkt=%0d pend=%0b err=%0d",
               i, rd_valid, rd_data, fifo_count, pkt_count, pending, err_count);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_pkt", i), 32'(pkt_count), 32'(tbl[i].epkt));
      chk($sformatf("vec%0d_pend", i), 32'(pending), 32'(tbl[i].epend));
      chk($sformatf("vec%0d_err", i), 32'(err_count), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
    end

    // Overflow: 33 bytes plus end-of-packet with no reads.
    for (int i = 0; i < 33; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("fill: count=%0d ovf=%0b pkt=%0d", fifo_count, overflow, pkt_count);
    chk("fill_count", 32'(fifo_count), 32'd32);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_pkt", 32'(pkt_count), 32'd0);
    chk("fill_head", 32'(rd_data), 32'h000);
    cyc(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("full pop+push: count=%0d head=%03h", fifo_count, rd_data);
    chk("fullpush_count", 32'(fifo_count), 32'd32);
    chk("fullpush_ovf", 32'(overflow), 32'd1);
    chk("fullpush_head", 32'(rd_data), 32'h001);

    // Error saturation, then clear.
    repeat (300) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("errors: err_count=%0d count=%0d", err_count, fifo_count);
    chk("err_sat", 32'(err_count), 32'd255);
    chk("err_count_fifo", 32'(fifo_count), 32'd32);
    chk("err_pending", 32'(pending), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("clear: err=%0d ovf=%0b count=%0d", err_count, overflow, fifo_count);
    chk("clr_err", 32'(err_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_count", 32'(fifo_count), 32'd0);
    chk("clr_valid", 32'(rd_valid), 32'd0);

    // Async reset mid-packet: 5 stored, 1 pending.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    chk("pre_rst_pend", 32'(pending), 32'd1);
    rx_data_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: valid=%0b count=%0d pend=%0b", rd_valid, fifo_count, pending);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_pkt", 32'(pkt_count), 32'd0);
    chk("arst_pend", 32'(pending), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("empty_rd_count", 32'(fifo_count), 32'd0);
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    // A push after the ignored empty pop must land at the head.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_rd_head", 32'(rd_data), 32'h13C);

    // Randomized traffic against the model, alternating read pressure.
    verbose_pops = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      int rd_pct = (blk % 2 == 0) ? 10 : 75;
      for (int c = 0; c < 300; c++) begin
        bit rdy  = ($urandom_range(99) < 45);
        bit eop  = ($urandom_range(99) < 15);
        bit er   = ($urandom_range(99) < 5);
        bit rd   = ($urandom_range(99) < rd_pct);
        bit clr  = ($urandom_range(999) < 2);
        cyc(rdy, 8'($urandom), er, eop, rd, clr, !rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
